// File: rtl/des_pkg.sv
// Shared constants and helpers for the DES input datapath.
package des_pkg;

   localparam int DES_BLK_W = 64;

   // Reference plaintext and its initial-permutation image
   localparam logic [DES_BLK_W-1:0] TV_PT = 64'h0123456789ABCDEF;
   localparam logic [DES_BLK_W-1:0] TV_IP = 64'hCC00CCFFF0AAF0AA;

   // Number of beats of width in_w that make up one DES block
   function automatic int beats(input int in_w);
      return DES_BLK_W / in_w;
   endfunction

endpackage

// File: rtl/des_blk_fifo2.sv
// One- or two-entry 64-bit FIFO holding completed DES blocks.
// A push while full and a pop while empty are both ignored.
module des_blk_fifo2
   import des_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [DES_BLK_W-1:0] push_data,
   input  logic                 pop,
   output logic                 full,
   output logic                 empty,
   output logic [DES_BLK_W-1:0] head
);

   localparam logic       LAST_PTR = 1'(DEPTH - 1);
   localparam logic [1:0] FULL_CNT = 2'(DEPTH);

   logic [DES_BLK_W-1:0] mem_q [2];
   logic                 wr_ptr_q, wr_ptr_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic [1:0]           count_q, count_d;
   logic                 do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == 2'd0);
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointer wrap and occupancy bookkeeping
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? 1'b0 : 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? 1'b0 : 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 2'd1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 2'd1;
      end
   end

   // Storage and pointer registers; reset also clears the data so head reads 0
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/des_block_loader.sv
// Assembles IN_W-bit beats into 64-bit DES blocks (first beat MSB = DES
// bit 1) and buffers completed blocks for the initial-permutation stage.
module des_block_loader
   import des_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] in_data,
   input  logic            abort,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [1:64]     out_block,
   output logic            partial,
   output logic [15:0]     blk_cnt
);

   localparam int            BEATS     = beats(IN_W);
   localparam int            CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
   logic [DES_BLK_W-1:0] asm_q, asm_d;
   logic [15:0]          blk_cnt_q, blk_cnt_d;
   logic [DES_BLK_W-1:0] blk_word;
   logic [DES_BLK_W-1:0] fifo_head;
   logic                 fifo_full, fifo_empty;
   logic                 completing, accept, push, pop;

   // The completing-beat stall looks only at buffer fullness, never at
   // out_ready, so in_ready has no combinational path from downstream.
   assign completing = (beat_cnt_q == LAST_BEAT);
   assign in_ready   = !(completing && fifo_full);
   assign accept     = in_valid && in_ready && !abort;
   assign out_valid  = !fifo_empty;
   assign pop        = out_valid && out_ready;
   assign out_block  = fifo_head;
   assign partial    = (beat_cnt_q != '0);
   assign blk_cnt    = blk_cnt_q;

   // Merge the incoming beat into its slot of the assembly word
   always_comb begin
      blk_word = asm_q;
      blk_word[(DES_BLK_W - 1) - int'(beat_cnt_q) * IN_W -: IN_W] = in_data;
   end

   // Beat counting, abort handling and block hand-over to the buffer
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      asm_d      = asm_q;
      push       = 1'b0;
      blk_cnt_d  = blk_cnt_q + 16'(pop);
      if (abort) begin
         beat_cnt_d = '0;
         asm_d      = '0;
      end else if (accept) begin
         if (completing) begin
            push       = 1'b1;
            beat_cnt_d = '0;
            asm_d      = '0;
         end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
            asm_d      = blk_word;
         end
      end
   end

   // Assembly state and hand-off counter
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_q <= '0;
         asm_q      <= '0;
         blk_cnt_q  <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         asm_q      <= asm_d;
         blk_cnt_q  <= blk_cnt_d;
      end
   end

   des_blk_fifo2 #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (blk_word),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

endmodule
